// File: rtl/ic_data_ram_par.sv
// ic_data_ram_par
// ---------------
// Parity-protected instruction-cache data array. The refill engine writes whole
// lines. The tag/hit side reads one word per request. Each stored word carries
// one even-parity bit. A read that hits the line being written in the same
// cycle receives the incoming fill data directly, so it never sees stale
// content. An optional output register stage adds one cycle of read latency.
// Parity errors on delivered words feed a sticky log: a saturating counter plus
// the address of the first logged error.
//
// Handshake: a read has no back-pressure. A request sampled with i_rd_en=1
// produces exactly one o_rd_valid pulse, 1+OUT_REG cycles later. o_rd_data and
// o_rd_err are meaningful only while o_rd_valid=1, and they hold their last
// values at other times. A fill is a single-cycle i_wr_en pulse.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_rd_en           read request
//   i_rd_way/line/word  read address (way, line index, word in line)
//   o_rd_data         delivered word (unmodified, even on parity error)
//   o_rd_valid        o_rd_data/o_rd_err valid this cycle
//   o_rd_err          parity mismatch on the delivered word
//   i_wr_en           line fill write
//   i_wr_way/line     fill address
//   i_wr_data         fill data, word k at [k*WORD_W +: WORD_W]
//   i_err_inj_en      with i_wr_en: store inverted parity for every word
//   i_err_clr         clear the error log
//   o_err_cnt         saturating count of delivered parity errors
//   o_err_way/line/word  address of the first logged error
module ic_data_ram_par #(
    parameter int WAYS    = 2,
    parameter int LINES   = 128,
    parameter int WORDS   = 4,
    parameter int WORD_W  = 16,
    parameter int OUT_REG = 0,
    parameter int CNT_W   = 8,
    localparam int WAY_W   = $clog2(WAYS),
    localparam int LINE_W  = $clog2(LINES),
    localparam int WORD_AW = $clog2(WORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_rd_en,
    input  logic [WAY_W-1:0]        i_rd_way,
    input  logic [LINE_W-1:0]       i_rd_line,
    input  logic [WORD_AW-1:0]      i_rd_word,
    output logic [WORD_W-1:0]       o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_rd_err,
    input  logic                    i_wr_en,
    input  logic [WAY_W-1:0]        i_wr_way,
    input  logic [LINE_W-1:0]       i_wr_line,
    input  logic [WORDS*WORD_W-1:0] i_wr_data,
    input  logic                    i_err_inj_en,
    input  logic                    i_err_clr,
    output logic [CNT_W-1:0]        o_err_cnt,
    output logic [WAY_W-1:0]        o_err_way,
    output logic [LINE_W-1:0]       o_err_line,
    output logic [WORD_AW-1:0]      o_err_word
);

    // Each stored word occupies a slot of {parity, data}.
    localparam int SLOT_W = WORD_W + 1;
    localparam int ENT_W  = WORDS * SLOT_W;
    localparam int DEPTH  = WAYS * LINES;
    localparam int IDX_W  = LINE_W + WAY_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENT_W-1:0] r_mem [DEPTH];

    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [ENT_W-1:0]  w_wr_ent;
    logic [ENT_W-1:0]  w_rd_ent;
    logic [SLOT_W-1:0] w_mem_slot;
    logic [SLOT_W-1:0] w_fwd_slot;
    logic              w_coll;

    assign w_wr_idx = {i_wr_line, i_wr_way};
    assign w_rd_idx = {i_rd_line, i_rd_way};
    assign w_rd_ent = r_mem[w_rd_idx];

    // A same-cycle fill of the exact entry being read wins over the array.
    assign w_coll = i_rd_en && i_wr_en &&
                    (i_rd_line == i_wr_line) && (i_rd_way == i_wr_way);

    // Build the stored line. Injection flips every parity bit, which makes
    // each word of the line fail its check on a later read.
    always_comb begin
        w_wr_ent = '0;
        for (int k = 0; k < WORDS; k++) begin
            w_wr_ent[k*SLOT_W +: SLOT_W] =
                {(^i_wr_data[k*WORD_W +: WORD_W]) ^ i_err_inj_en,
                 i_wr_data[k*WORD_W +: WORD_W]};
        end
    end

    // Word select for the array word and for the forwarded word. Forwarded
    // data gets freshly computed parity, so injection never reaches it.
    always_comb begin
        w_mem_slot = '0;
        w_fwd_slot = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (i_rd_word == WORD_AW'(k)) begin
                w_mem_slot = w_rd_ent[k*SLOT_W +: SLOT_W];
                w_fwd_slot = {^i_wr_data[k*WORD_W +: WORD_W],
                              i_wr_data[k*WORD_W +: WORD_W]};
            end
        end
    end

    // The array has no reset. A fill sampled during reset is discarded.
    always_ff @(posedge clk) begin
        if (rst_n && i_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_ent;
        end
    end

    // Stage 1: the registered read. The address travels with the data for
    // error logging. Slot and address registers load only on a request, so
    // they hold their values between reads.
    logic              r_s1_valid;
    logic [SLOT_W-1:0] r_s1_slot;
    logic [WAY_W-1:0]  r_s1_way;
    logic [LINE_W-1:0] r_s1_line;
    logic [WORD_AW-1:0] r_s1_word;
    logic              w_s1_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_slot  <= '0;
            r_s1_way   <= '0;
            r_s1_line  <= '0;
            r_s1_word  <= '0;
        end else begin
            r_s1_valid <= i_rd_en;
            if (i_rd_en) begin
                r_s1_slot <= w_coll ? w_fwd_slot : w_mem_slot;
                r_s1_way  <= i_rd_way;
                r_s1_line <= i_rd_line;
                r_s1_word <= i_rd_word;
            end
        end
    end

    // An even-parity slot XORs to zero, so any 1 means a mismatch.
    assign w_s1_err = ^r_s1_slot;

    logic               w_out_valid;
    logic               w_out_err;
    logic [WORD_W-1:0]  w_out_data;
    logic [WAY_W-1:0]   w_out_way;
    logic [LINE_W-1:0]  w_out_line;
    logic [WORD_AW-1:0] w_out_word;

    if (OUT_REG != 0) begin : g_out_reg
        logic               r_s2_valid;
        logic               r_s2_err;
        logic [WORD_W-1:0]  r_s2_data;
        logic [WAY_W-1:0]   r_s2_way;
        logic [LINE_W-1:0]  r_s2_line;
        logic [WORD_AW-1:0] r_s2_word;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_err   <= 1'b0;
                r_s2_data  <= '0;
                r_s2_way   <= '0;
                r_s2_line  <= '0;
                r_s2_word  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_err  <= w_s1_err;
                    r_s2_data <= r_s1_slot[WORD_W-1:0];
                    r_s2_way  <= r_s1_way;
                    r_s2_line <= r_s1_line;
                    r_s2_word <= r_s1_word;
                end
            end
        end

        assign w_out_valid = r_s2_valid;
        assign w_out_err   = r_s2_err;
        assign w_out_data  = r_s2_data;
        assign w_out_way   = r_s2_way;
        assign w_out_line  = r_s2_line;
        assign w_out_word  = r_s2_word;
    end else begin : g_no_out_reg
        assign w_out_valid = r_s1_valid;
        assign w_out_err   = w_s1_err;
        assign w_out_data  = r_s1_slot[WORD_W-1:0];
        assign w_out_way   = r_s1_way;
        assign w_out_line  = r_s1_line;
        assign w_out_word  = r_s1_word;
    end

    assign o_rd_valid = w_out_valid;
    assign o_rd_err   = w_out_err;
    assign o_rd_data  = w_out_data;

    // Error log. A clear in the same cycle as an error is applied first, so
    // the error then counts as the first one and its address is captured.
    logic [CNT_W-1:0]   r_err_cnt;
    logic [WAY_W-1:0]   r_err_way;
    logic [LINE_W-1:0]  r_err_line;
    logic [WORD_AW-1:0] r_err_word;
    logic [CNT_W-1:0]   w_cnt_base;
    logic               w_err_evt;

    assign w_cnt_base = i_err_clr ? '0 : r_err_cnt;
    assign w_err_evt  = w_out_valid && w_out_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt  <= '0;
            r_err_way  <= '0;
            r_err_line <= '0;
            r_err_word <= '0;
        end else if (w_err_evt) begin
            r_err_cnt <= (w_cnt_base == CNT_MAX) ? w_cnt_base
                                                 : w_cnt_base + CNT_W'(1);
            if (w_cnt_base == '0) begin
                r_err_way  <= w_out_way;
                r_err_line <= w_out_line;
                r_err_word <= w_out_word;
            end
        end else if (i_err_clr) begin
            r_err_cnt  <= '0;
            r_err_way  <= '0;
            r_err_line <= '0;
            r_err_word <= '0;
        end
    end

    assign o_err_cnt  = r_err_cnt;
    assign o_err_way  = r_err_way;
    assign o_err_line = r_err_line;
    assign o_err_word = r_err_word;

endmodule

// File: tb/tb_ic_data_ram_par.sv
// Bench for ic_data_ram_par. Two instances share one stimulus stream:
//   dut_a: OUT_REG=0, CNT_W=8 (read latency 1)
//   dut_b: OUT_REG=1, CNT_W=2 (read latency 2, counter saturates at 3)
// Each read pushes {err, data} onto a queue per instance. A negedge monitor
// pops an entry and compares it whenever that instance raises rd_valid.
module tb_ic_data_ram_par;

    localparam int WORD_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd_en;
    logic [0:0]  rd_way;
    logic [6:0]  rd_line;
    logic [1:0]  rd_word;
    logic        wr_en;
    logic [0:0]  wr_way;
    logic [6:0]  wr_line;
    logic [63:0] wr_data;
    logic        err_inj_en;
    logic        err_clr;

    logic [15:0] a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid;
    logic        a_rd_err, b_rd_err;
    logic [7:0]  a_err_cnt;
    logic [1:0]  b_err_cnt;
    logic [0:0]  a_err_way, b_err_way;
    logic [6:0]  a_err_line, b_err_line;
    logic [1:0]  a_err_word, b_err_word;

    ic_data_ram_par #(.OUT_REG(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_rd_en(rd_en), .i_rd_way(rd_way), .i_rd_line(rd_line), .i_rd_word(rd_word),
        .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .o_rd_err(a_rd_err),
        .i_wr_en(wr_en), .i_wr_way(wr_way), .i_wr_line(wr_line), .i_wr_data(wr_data),
        .i_err_inj_en(err_inj_en), .i_err_clr(err_clr),
        .o_err_cnt(a_err_cnt), .o_err_way(a_err_way), .o_err_line(a_err_line),
        .o_err_word(a_err_word)
    );

    ic_data_ram_par #(.OUT_REG(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_rd_en(rd_en), .i_rd_way(rd_way), .i_rd_line(rd_line), .i_rd_word(rd_word),
        .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .o_rd_err(b_rd_err),
        .i_wr_en(wr_en), .i_wr_way(wr_way), .i_wr_line(wr_line), .i_wr_data(wr_data),
        .i_err_inj_en(err_inj_en), .i_err_clr(err_clr),
        .o_err_cnt(b_err_cnt), .o_err_way(b_err_way), .o_err_line(b_err_line),
        .o_err_word(b_err_word)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [WORD_W:0] exp_a_q[$];
    logic [WORD_W:0] exp_b_q[$];
    logic [WORD_W:0] e_a, e_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sampled on the inactive edge.
    always @(negedge clk) begin
        if (a_rd_valid === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_rd_valid", 1, 0);
            end else begin
                e_a = exp_a_q.pop_front();
                check("a_rd_data", a_rd_data, e_a[15:0]);
                check("a_rd_err", a_rd_err, e_a[16]);
            end
        end
        if (b_rd_valid === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_rd_valid", 1, 0);
            end else begin
                e_b = exp_b_q.pop_front();
                check("b_rd_data", b_rd_data, e_b[15:0]);
                check("b_rd_err", b_rd_err, e_b[16]);
            end
        end
    end

    // Driver tasks
    task automatic idle();
        rd_en = 1'b0; rd_way = '0; rd_line = '0; rd_word = '0;
        wr_en = 1'b0; wr_way = '0; wr_line = '0; wr_data = '0;
        err_inj_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic drain();
        repeat (4) step();
    endtask

    task automatic rd(input logic way, input logic [6:0] line, input logic [1:0] word,
                      input logic [15:0] exp_data, input logic exp_err, input bit push_b);
        rd_en = 1'b1; rd_way = way; rd_line = line; rd_word = word;
        exp_a_q.push_back({exp_err, exp_data});
        if (push_b) exp_b_q.push_back({exp_err, exp_data});
    endtask

    task automatic wr(input logic way, input logic [6:0] line, input logic [63:0] data,
                      input logic inj);
        wr_en = 1'b1; wr_way = way; wr_line = line; wr_data = data; err_inj_en = inj;
    endtask

    task automatic check_log(input string tag, input int a_cnt, input int b_cnt,
                             input int way, input int line, input int word);
        check({tag, "_a_err_cnt"}, a_err_cnt, a_cnt);
        check({tag, "_b_err_cnt"}, b_err_cnt, b_cnt);
        check({tag, "_a_err_way"}, a_err_way, way);
        check({tag, "_b_err_way"}, b_err_way, way);
        check({tag, "_a_err_line"}, a_err_line, line);
        check({tag, "_b_err_line"}, b_err_line, line);
        check({tag, "_a_err_word"}, a_err_word, word);
        check({tag, "_b_err_word"}, b_err_word, word);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a_rd_valid"}, a_rd_valid, 0);
        check({tag, "_b_rd_valid"}, b_rd_valid, 0);
        check({tag, "_a_rd_data"}, a_rd_data, 0);
        check({tag, "_b_rd_data"}, b_rd_data, 0);
        check({tag, "_a_rd_err"}, a_rd_err, 0);
        check({tag, "_b_rd_err"}, b_rd_err, 0);
        check_log(tag, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic        way;
        logic [6:0]  line;
        logic [63:0] data;
    } fill_t;

    typedef struct {
        logic        way;
        logic [6:0]  line;
        logic [1:0]  word;
        logic [15:0] exp_data;
        logic        exp_err;
    } rvec_t;

    fill_t fills[3];
    rvec_t rvecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fills[0] = '{1'b1, 7'd5, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        fills[1] = '{1'b0, 7'd7, {16'hAAAA, 16'hA002, 16'hA001, 16'hA000}};
        fills[2] = '{1'b1, 7'd7, {16'h5554, 16'h5553, 16'h5552, 16'h5551}};

        rvecs[0] = '{1'b1, 7'd5, 2'd2, 16'h3333, 1'b0};
        rvecs[1] = '{1'b1, 7'd5, 2'd0, 16'h1111, 1'b0};
        rvecs[2] = '{1'b1, 7'd5, 2'd3, 16'h4444, 1'b0};
        rvecs[3] = '{1'b0, 7'd7, 2'd3, 16'hAAAA, 1'b0};
        rvecs[4] = '{1'b0, 7'd7, 2'd1, 16'hA001, 1'b0};
        rvecs[5] = '{1'b1, 7'd7, 2'd1, 16'h5552, 1'b0};

        // Reset
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // Basic fill, then table-driven back-to-back reads
        for (int i = 0; i < 3; i++) begin
            wr(fills[i].way, fills[i].line, fills[i].data, 1'b0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            rd(rvecs[i].way, rvecs[i].line, rvecs[i].word,
               rvecs[i].exp_data, rvecs[i].exp_err, 1'b1);
            step();
        end
        drain();
        check("hold_a_rd_data", a_rd_data, 16'h5552);
        check("hold_b_rd_data", b_rd_data, 16'h5552);
        check("hold_a_rd_valid", a_rd_valid, 0);
        check("hold_b_rd_valid", b_rd_valid, 0);

        // Collision: same way forwards new data, other way returns old data
        wr(1'b0, 7'd7, {16'hBEEF, 16'h7772, 16'h7771, 16'h7770}, 1'b0);
        rd(1'b0, 7'd7, 2'd3, 16'hBEEF, 1'b0, 1'b1);
        step();
        wr(1'b0, 7'd7, {16'hBEEF, 16'h7772, 16'h7771, 16'h7770}, 1'b0);
        rd(1'b1, 7'd7, 2'd2, 16'h5553, 1'b0, 1'b1);
        step();
        // Forwarded data bypasses injection
        wr(1'b0, 7'd7, {16'hBEEF, 16'h7772, 16'h7771, 16'h7770}, 1'b1);
        rd(1'b0, 7'd7, 2'd1, 16'h7771, 1'b0, 1'b1);
        step();
        wr(1'b0, 7'd7, {16'hBEEF, 16'h7772, 16'h7771, 16'h7770}, 1'b0);
        step();
        rd(1'b0, 7'd7, 2'd3, 16'hBEEF, 1'b0, 1'b1);
        step();
        rd(1'b0, 7'd7, 2'd0, 16'h7770, 1'b0, 1'b1);
        step();
        drain();
        check_log("no_err", 0, 0, 0, 0, 0);

        // Injection: every word of line 9 way 0 reports an error
        wr(1'b0, 7'd9, {16'h9993, 16'h9992, 16'h9991, 16'h9990}, 1'b1);
        step();
        for (int w = 0; w < 4; w++) begin
            rd(1'b0, 7'd9, 2'(w), 16'h9990 + 16'(w), 1'b1, 1'b1);
            step();
        end
        drain();
        check_log("inject", 4, 3, 0, 9, 0);
        wr(1'b0, 7'd9, {16'h9993, 16'h9992, 16'h9991, 16'h9990}, 1'b0);
        step();
        rd(1'b0, 7'd9, 2'd2, 16'h9992, 1'b0, 1'b1);
        step();
        drain();
        check("clean_a_err_cnt", a_err_cnt, 4);

        // Clear alone
        err_clr = 1'b1;
        step();
        check_log("clear1", 0, 0, 0, 0, 0);

        // Saturation, then clear coinciding with an error
        wr(1'b1, 7'd12, {16'hC003, 16'hC002, 16'hC001, 16'hC000}, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            rd(1'b1, 7'd12, 2'(i % 4), 16'hC000 + 16'(i % 4), 1'b1, 1'b1);
            step();
        end
        drain();
        check_log("saturate", 5, 3, 1, 12, 0);
        // Dut_a delivers these two errors one cycle before dut_b does. The
        // single clear pulse coincides with the second error on dut_a and the
        // first error on dut_b.
        rd(1'b1, 7'd12, 2'd1, 16'hC001, 1'b1, 1'b1);
        step();
        rd(1'b1, 7'd12, 2'd1, 16'hC001, 1'b1, 1'b1);
        step();
        err_clr = 1'b1;
        step();
        drain();
        check_log("clr_with_err", 1, 2, 1, 12, 1);
        err_clr = 1'b1;
        step();
        check_log("clear2", 0, 0, 0, 0, 0);

        // OUT_REG pipeline: four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            rd(1'b1, 7'd5, 2'(i), 16'h1111 * 16'(i + 1), 1'b0, 1'b1);
            step();
            check("b2b_a_rd_valid", a_rd_valid, 1);
            check("b2b_b_rd_valid", b_rd_valid, (i >= 1) ? 1 : 0);
        end
        step();
        check("b2b_tail_a_rd_valid", a_rd_valid, 0);
        check("b2b_tail_b_rd_valid", b_rd_valid, 1);
        step();
        check("b2b_end_b_rd_valid", b_rd_valid, 0);
        check("b2b_hold_a_rd_data", a_rd_data, 16'h4444);
        check("b2b_hold_b_rd_data", b_rd_data, 16'h4444);

        // Reset mid-read; log made nonzero first so reset has something to clear
        rd(1'b1, 7'd12, 2'd0, 16'hC000, 1'b1, 1'b1);
        step();
        drain();
        check_log("pre_reset", 1, 1, 1, 12, 0);
        // Dut_a delivers before reset lands; dut_b's read is dropped.
        rd(1'b1, 7'd5, 2'd2, 16'h3333, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        wr(1'b1, 7'd5, {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD}, 1'b0);
        step();
        step();
        check_idle_outputs("mid_reset");
        rst_n = 1'b1;
        step();
        step();
        check("post_reset_b_rd_valid", b_rd_valid, 0);
        rd(1'b1, 7'd5, 2'd2, 16'h3333, 1'b0, 1'b1);
        step();
        rd(1'b1, 7'd5, 2'd3, 16'h4444, 1'b0, 1'b1);
        step();
        drain();

        check("a_queue_empty", exp_a_q.size(), 0);
        check("b_queue_empty", exp_b_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ic_data_ram_par.md
Name: ic_data_ram_par

Overview:
Parametrised, parity-protected instruction-cache data array: next generation of the cache data RAM. Full-line fill writes, single-word reads, and read/write collision forwarding. Adds per-word even parity, an optional output register stage, write-side error injection, and a sticky error log (saturating count plus first-error address). Sits between the tag/hit logic (read side) and the refill engine (write side).

Parameters:
WAYS, 2, number of ways (power of 2, >=2)
LINES, 128, lines per way (power of 2)
WORDS, 4, words per line (power of 2, >=2)
WORD_W, 16, bits per word
OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
CNT_W, 8, width of the saturating error counter
Derived: WAY_W=$clog2(WAYS), LINE_W=$clog2(LINES), WORD_AW=$clog2(WORDS)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rd_en  in  1  read request
rd_way  in  WAY_W  read way
rd_line  in  LINE_W  read line index
rd_word  in  WORD_AW  word within line
rd_data  out  WORD_W  read word
rd_valid  out  1  rd_data/rd_err valid this cycle
rd_err  out  1  parity mismatch on delivered word
wr_en  in  1  line fill write
wr_way  in  WAY_W  fill way
wr_line  in  LINE_W  fill line index
wr_data  in  WORDS*WORD_W  fill data; word k at [k*WORD_W +: WORD_W]
err_inj_en  in  1  with wr_en: store inverted parity for every word of the line
err_clr  in  1  clear error log
err_cnt  out  CNT_W  saturating count of rd_err events
err_way  out  WAY_W  way of first logged error
err_line  out  LINE_W  line of first logged error
err_word  out  WORD_AW  word of first logged error

Behaviour:
- Clock clk; reset rst_n, synchronous, active-low.
- Storage: WAYS*LINES entries, index {line,way}. Each entry is WORDS x (WORD_W+1); the extra bit is even parity (^word). RAM contents are not reset.
- Write (wr_en=1): entry[{wr_line,wr_way}] <= each word plus its parity. If err_inj_en=1, every stored parity bit is inverted. Write takes effect at the clock edge.
- Read (rd_en=1): word rd_word of entry[{rd_line,rd_way}] is returned.
  - Latency L=1+OUT_REG. rd_valid=1 exactly L cycles after rd_en, for one cycle per request.
  - Back-to-back reads are accepted every cycle.
  - When rd_valid=0, rd_data and rd_err hold their last values.
- Collision: rd_en && wr_en && rd_line==wr_line && rd_way==wr_way.
  - Returns word rd_word of wr_data, with rd_err=0; forwarded data bypasses injection.
  - Same line, different way: returns old RAM content of the read way.
- Parity check: rd_err = (^stored_word) != stored_parity, aligned with rd_data. rd_data is delivered unmodified even on error.
- Way, line and word of each read are pipelined alongside the data for logging.
- Error log, updated on cycles with rd_valid && rd_err:
  - err_cnt increments and saturates at 2^CNT_W-1.
  - If err_cnt==0 before the increment, err_way/err_line/err_word capture the failing address.
  - err_clr=1 zeroes err_cnt and the capture registers. If an error arrives in the same cycle, the clear is applied first: result is err_cnt=1 with the new address captured.
- Reset values: rd_data=0, rd_valid=0, rd_err=0, err_cnt=0, err_way=0, err_line=0, err_word=0. All pipeline valids are cleared.
- Reset mid-operation: in-flight reads are dropped (no rd_valid after reset). A write in the reset cycle is ignored.
- Reads of never-written entries return undefined data. The bench must fill an entry before reading it.

Test Plan:
- Basic fill/read: write line 5, way 1, words {0x1111,0x2222,0x3333,0x4444}; next cycle read word 2 -> rd_data=0x3333, rd_valid 1 cycle later (OUT_REG=0), rd_err=0.
- Collision: line 7/way 0 holds 0xAAAA in word 3. Write line 7/way 0 with word3=0xBEEF while reading line 7/way 0 word 3 in the same cycle -> rd_data=0xBEEF, rd_err=0. Same stimulus with a read of way 1 -> old way-1 content.
- Injection: write line 9, way 0 with err_inj_en=1; read words 0..3 -> rd_err=1 on each, err_cnt=4, err_line=9, err_way=0, err_word=0. A clean rewrite followed by a read -> rd_err=0.
- Saturation/clear (CNT_W=2): 5 error reads -> err_cnt=3. Assert err_clr on the cycle of an error on line 12, word 1 -> err_cnt=1, err_line=12, err_word=1. err_clr alone -> all log outputs 0.
- OUT_REG=1: reads issued every cycle to words 0,1,2,3 -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd_en, data in order. rd_data holds word 3 afterwards.
- Reset mid-read: rd_en at cycle N, rst_n=0 at N+1 -> no rd_valid. All outputs 0 after reset; previously written data is readable after reset.
